// File: rtl/compare_pkg.sv
// compare_pkg: shared defaults, result codes and FSM encoding for compare_arbiter
package compare_pkg;
    localparam int NREQ_DEF = 4;
    localparam int W_DEF = 8;
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;
    typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/compare_arbiter_rr_grant.sv
// rr_grant: combinational round-robin one-hot grant starting the search at ptr
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic [IDW-1:0] k;
    // walk offsets from farthest to nearest so the nearest set request wins
    always_comb begin
        gnt = '0;
        idx = '0;
        k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = ptr + IDW'(i);
            if (req[k]) begin
                gnt = NREQ'(1) << k;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin shared unsigned comparator with valid/ready one-hot result
module compare_arbiter
    import compare_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W = W_DEF,
    parameter int IDW = $clog2(NREQ)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [NREQ-1:0]   iReq,
    input  logic [NREQ*W-1:0] iData_a,
    input  logic [NREQ*W-1:0] iData_b,
    output logic [NREQ-1:0]   oAck,
    output logic              oValid,
    output logic [2:0]        oData,
    output logic [IDW-1:0]    oId,
    input  logic              iReady
);
    state_t state, nextState;
    logic [IDW-1:0] ptr, gntIdx, idReg;
    logic [NREQ-1:0] gnt;
    logic [W-1:0] aReg, bReg;
    logic [2:0] cmpRes;
    logic take;

    rr_grant #(.NREQ(NREQ), .IDW(IDW)) uGrant (
        .req(iReq),
        .ptr(ptr),
        .gnt(gnt),
        .idx(gntIdx)
    );

    assign take = (state == IDLE) && (|gnt);

    // state register
    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else state <= nextState;
    end

    // next-state: one accept, one compare cycle, then hold until consumed
    always_comb begin
        nextState = (state == IDLE) ? (take ? CMP : IDLE) :
                    (state == CMP)  ? RESP :
                    (iReady ? IDLE : RESP);
    end

    // accept strobe only in IDLE and never while reset is asserted
    always_comb begin
        oAck = (state == IDLE && !iRst) ? gnt : '0;
    end

    // unsigned magnitude compare of the latched operand pair
    always_comb begin
        cmpRes = (aReg > bReg) ? CMP_GT : (aReg < bReg) ? CMP_LT : CMP_EQ;
    end

    // operand latch, pointer advance and registered response
    always_ff @(posedge iClk) begin
        if (iRst) begin
            ptr <= '0;
            oValid <= 1'b0;
            oData <= '0;
            oId <= '0;
        end else begin
            if (take) begin
                aReg <= iData_a[gntIdx*W +: W];
                bReg <= iData_b[gntIdx*W +: W];
                idReg <= gntIdx;
                ptr <= gntIdx + IDW'(1);
            end
            if (state == CMP) begin
                oData <= cmpRes;
                oId <= idReg;
                oValid <= 1'b1;
            end
            if (state == RESP && iReady) oValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: randomized scoreboard bench for compare_arbiter
module tb_compare_arbiter;
    localparam int NREQ = 4;
    localparam int W = 8;
    localparam int IDW = 2;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    logic iReady = 1'b0;
    logic [NREQ-1:0] iReq = '0;
    logic [NREQ-1:0] oAck;
    logic [NREQ*W-1:0] iData_a = '0;
    logic [NREQ*W-1:0] iData_b = '0;
    logic oValid;
    logic [2:0] oData;
    logic [IDW-1:0] oId;

    compare_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iReq(iReq),
        .iData_a(iData_a),
        .iData_b(iData_b),
        .oAck(oAck),
        .oValid(oValid),
        .oData(oData),
        .oId(oId),
        .iReady(iReady)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [2:0] res;
        int id;
        int exp;
        bit seen;
    } resp_t;

    resp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ptr = 0;
    bit pend[NREQ];
    logic [W-1:0] opA[NREQ];
    logic [W-1:0] opB[NREQ];

    always @(posedge iClk) cyc <= cyc + 1;

    function automatic logic [2:0] refCmp(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // monitor: compares every presented response against the scoreboard head
    initial begin
        forever begin
            @(negedge iClk);
            #2;
            if (oValid === 1'b1) begin
                if (q.size() == 0) begin
                    check("spuriousValid", 32'(oValid), 32'd0);
                end else begin
                    check("respData", 32'(oData), 32'(q[0].res));
                    check("respId", 32'(oId), 32'(q[0].id));
                    if (!q[0].seen) begin
                        check("respLatency", 32'(cyc), 32'(q[0].exp));
                        q[0].seen = 1'b1;
                    end
                    if (iReady && !iRst) void'(q.pop_front());
                end
            end else if (q.size() != 0 && cyc >= q[0].exp) begin
                check("missingValid", 32'(oValid), 32'd1);
            end
        end
    end

    // driver and reference model
    initial begin
        bit rstPrev;
        int g, reqPct, readyPct, rstPct;
        for (int k = 0; k < NREQ; k++) begin
            pend[k] = 1'b0;
            opA[k] = '0;
            opB[k] = '0;
        end
        repeat (3) @(negedge iClk);
        rstPrev = 1'b1;
        for (int ph = 0; ph < 4; ph++) begin
            reqPct = (ph == 0) ? 20 : (ph == 1) ? 100 : (ph == 2) ? 60 : 50;
            readyPct = (ph == 2) ? 25 : 90;
            rstPct = (ph == 3) ? 4 : 0;
            for (int n = 0; n < 300; n++) begin
                @(negedge iClk);
                if (rstPrev) begin
                    q.delete();
                    ptr = 0;
                    check("rstValid", 32'(oValid), 32'd0);
                    check("rstData", 32'(oData), 32'd0);
                    check("rstId", 32'(oId), 32'd0);
                end
                for (int k = 0; k < NREQ; k++) begin
                    if (!pend[k] && $urandom_range(99) < reqPct) begin
                        pend[k] = 1'b1;
                        opA[k] = W'($urandom);
                        opB[k] = ($urandom_range(3) == 0) ? opA[k] : W'($urandom);
                    end
                    iReq[k] = pend[k];
                    iData_a[k*W +: W] = opA[k];
                    iData_b[k*W +: W] = opB[k];
                end
                iReady = $urandom_range(99) < readyPct;
                iRst = $urandom_range(99) < rstPct;
                #1;
                g = (!iRst && q.size() == 0) ? pick(iReq, ptr) : -1;
                check("ack", 32'(oAck), (g >= 0) ? (32'd1 << g) : 32'd0);
                if (g >= 0) begin
                    q.push_back('{refCmp(opA[g], opB[g]), g, cyc + 2, 1'b0});
                    pend[g] = 1'b0;
                    ptr = (g + 1) % NREQ;
                end
                rstPrev = iRst;
            end
        end
        @(negedge iClk);
        iRst = 1'b0;
        iReq = '0;
        iReady = 1'b1;
        repeat (6) @(negedge iClk);
        check("drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
- Shares one unsigned W-bit magnitude comparator among NREQ requesters.
- Selects one pending request round-robin and latches its operand pair.
- Performs the compare in a dedicated cycle.
- Presents a one-hot result, tagged with the requester id, over a valid/ready response interface.
- Sits between the compare requesters in the datapath and a single downstream result consumer.

Parameters:
- NREQ, 4, number of requesters (power of two, 2..8).
- W, 8, operand width in bits.
- IDW, 2, requester id width (log2 NREQ).

Ports:
- iClk  in  1  clock; all state updates on its rising edge.
- iRst  in  1  synchronous active-high reset.
- iReq  in  NREQ  per-requester request valid.
- iData_a  in  NREQ*W  packed operand a; slice k is [k*W +: W].
- iData_b  in  NREQ*W  packed operand b; same packing.
- oAck  out  NREQ  one-hot accept strobe; iReq[k] & oAck[k] means request k is taken this cycle.
- oValid  out  1  response valid.
- oData  out  3  result: 100 = a>b, 010 = a<b, 001 = a==b.
- oId  out  IDW  index of the requester whose result is on oData.
- iReady  in  1  downstream ready; the response is consumed on oValid & iReady.

Behaviour:
- Reset:
  - Takes effect on any edge with iRst=1.
  - Clears state to IDLE and the round-robin pointer to 0.
  - Clears oValid, oData and oId to 0 (registers).
  - Forces oAck to 0 while iRst=1.
  - Reset in CMP or RESP discards the transaction; no response is ever emitted for it.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - oAck is combinational: the one-hot grant of the first set iReq bit, searching from the pointer upward modulo NREQ.
  - oAck is 0 if no iReq bit is set.
  - On an edge with a grant:
    - latch a, b and id of the granted requester;
    - set the pointer to (id+1) mod NREQ;
    - move to CMP.
- CMP:
  - oAck=0.
  - Compare the latched operands as unsigned; the MSB-first decision is equivalent to full magnitude compare.
  - Register the result into oData, the id into oId, and set oValid=1.
  - Move to RESP.
- RESP:
  - oAck=0.
  - oValid, oData and oId hold stable until iReady=1.
  - On oValid & iReady: clear oValid and return to IDLE.
- Latency and throughput:
  - Accept at cycle T gives oValid at T+2.
  - With iReady tied high, at most one accept per 3 cycles.
- Requester rules:
  - Operands must be stable while iReq is high and until oAck is seen.
  - Operands may change the cycle after accept.
  - A request still high after its accept is treated as a new request and competes normally.
- Other boundary conditions:
  - iReady outside RESP is ignored.
  - Pointer wrap: after granting NREQ-1, the pointer becomes 0.
  - If all requests are simultaneous, grant order starts at the pointer.
  - oData is never 000 or multi-hot while oValid=1.

Decomposition:
- Shared package compare_pkg holds:
  - W and NREQ defaults;
  - result constants CMP_GT=3'b100, CMP_LT=3'b010, CMP_EQ=3'b001;
  - FSM state encoding IDLE/CMP/RESP.
- One sub-module, rr_grant: combinational round-robin one-hot grant.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and granted index.
- The comparator is inline in compare_arbiter.

Test Plan:
- Basic compare: after reset, iReq=0001, a0=0x5A, b0=0x3C, iReady=1 -> oAck=0001 at T; oValid=1, oData=100, oId=0 at T+2; oValid=0 at T+3.
- Equal and less-than: req1 with a=b=0x80 -> oData=001, oId=1. Then req1 with a=0x7F, b=0x80 -> oData=010, oId=1.
- All four requesting from reset, held high, iReady=1 -> grants in order 0,1,2,3,0, spaced exactly 3 cycles apart; oId follows 0,1,2,3.
- Fairness: iReq=0101 held continuously -> grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- Backpressure: iReady=0 for 5 cycles in RESP -> oValid, oData and oId stable; oAck=0 throughout. Raise iReady -> oValid drops next cycle and the next accept occurs in that IDLE cycle.
- Reset in CMP:
  - Stimulus: assert iRst for 1 cycle while in CMP.
  - Next cycle: oValid=0, oData=0, oId=0, pointer 0, no response for the aborted request.
  - A pending req3 with iReq=1000 then gets oAck=1000 on the first IDLE cycle.
